// File: rtl/spi_reg_ctrl.sv
// SPI register-access sequencer: turns the byte stream of a chip-select frame into
// command / burst-write / burst-read accesses on a simple register bank.
module spi_reg_ctrl #(
  parameter int              SIZE   = 8,
  parameter logic [SIZE-1:0] STATUS = 8'hA5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cs,
  input  logic [SIZE-1:0] rx_data,
  input  logic            rx_valid,
  output logic [SIZE-1:0] tx_data,
  output logic [SIZE-2:0] reg_addr,
  output logic [SIZE-1:0] reg_wdata,
  output logic            reg_we,
  output logic            reg_re,
  input  logic [SIZE-1:0] reg_rdata,
  output logic            busy
);

  typedef enum logic [2:0] {IDLE, CMD, WR, RD_REQ, RD_CAP, RD} state_t;

  state_t state, state_nxt;

  logic rx_valid_p1;
  logic rx_strobe;
  logic armed;
  logic we_p1;
  logic we_set;
  logic ld_cmd;
  logic ld_wdata;
  logic ld_rdata;
  logic inc_addr;
  logic rd_req;

  function automatic logic [SIZE-2:0] addr_inc(input logic [SIZE-2:0] a);
    return a + {{(SIZE-2){1'b0}}, 1'b1};
  endfunction

  // The edge detector is cleared while cs is high, so a valid level held across a
  // frame boundary strobes only in the IDLE cycle, where it is ignored.
  assign rx_strobe = rx_valid & ~rx_valid_p1 & ~cs;

  always_comb begin
    state_nxt = state;
    we_set    = 1'b0;
    ld_cmd    = 1'b0;
    ld_wdata  = 1'b0;
    ld_rdata  = 1'b0;
    inc_addr  = 1'b0;
    rd_req    = 1'b0;
    if (cs) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          // Only a cs falling edge seen after reset release opens a frame.
          if (armed) state_nxt = CMD;
        end
        CMD: begin
          if (rx_strobe) begin
            ld_cmd    = 1'b1;
            state_nxt = rx_data[SIZE-1] ? RD_REQ : WR;
          end
        end
        WR: begin
          if (rx_strobe) begin
            ld_wdata = 1'b1;
            we_set   = 1'b1;
          end
          inc_addr = we_p1;
        end
        RD_REQ: begin
          rd_req    = 1'b1;
          state_nxt = RD_CAP;
        end
        RD_CAP: begin
          ld_rdata  = 1'b1;
          inc_addr  = 1'b1;
          state_nxt = RD;
        end
        RD: begin
          if (rx_strobe) state_nxt = RD_REQ;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Stage p1: state, strobe history, write strobe and access registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      rx_valid_p1 <= 1'b0;
      armed       <= 1'b0;
      we_p1       <= 1'b0;
      tx_data     <= STATUS;
      reg_addr    <= '0;
      reg_wdata   <= '0;
    end else begin
      state       <= state_nxt;
      rx_valid_p1 <= cs ? 1'b0 : rx_valid;
      armed       <= armed | cs;
      we_p1       <= we_set;
      if (state == IDLE) tx_data <= STATUS;
      else if (ld_rdata) tx_data <= reg_rdata;
      if (ld_cmd) reg_addr <= rx_data[SIZE-2:0];
      else if (inc_addr) reg_addr <= addr_inc(reg_addr);
      if (ld_wdata) reg_wdata <= rx_data;
    end
  end

  assign reg_we = we_p1 & ~cs;
  assign reg_re = rd_req;
  assign busy   = (state != IDLE);

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl: a register-bank model answers reads, and a
// negedge monitor logs every write/read strobe for later comparison.
module tb_spi_reg_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       cs;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  spi_reg_ctrl #(.SIZE(8), .STATUS(8'hA5)) dut (
    .clk       (clk),
    .reset     (reset),
    .cs        (cs),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata),
    .busy      (busy)
  );

  logic [7:0] mem  [0:127];
  logic [6:0] we_a [0:255];
  logic [7:0] we_d [0:255];
  logic [6:0] re_a [0:255];
  int we_n = 0;
  int re_n = 0;
  int overlap = 0;

  // Register bank: read data appears the clock after reg_re.
  always @(negedge clk) begin
    if (reg_we) begin
      mem[reg_addr]   <= reg_wdata;
      we_a[we_n[7:0]] <= reg_addr;
      we_d[we_n[7:0]] <= reg_wdata;
      we_n            <= we_n + 1;
    end
    if (reg_re) begin
      reg_rdata       <= mem[reg_addr];
      re_a[re_n[7:0]] <= reg_addr;
      re_n            <= re_n + 1;
    end
    if (reg_we && reg_re) overlap <= overlap + 1;
  end

  function automatic logic [6:0] wa(input int i);
    return we_a[i[7:0]];
  endfunction

  function automatic logic [7:0] wd(input int i);
    return we_d[i[7:0]];
  endfunction

  function automatic logic [6:0] ra(input int i);
    return re_a[i[7:0]];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick(6);
    rx_valid = 1'b0;
    tick(6);
  endtask

  initial begin
    int b;
    int rb;
    logic [7:0] miso [0:3];

    reset    = 1'b0;
    cs       = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tick(2);
    chk("rst_busy", busy, 0);
    chk("rst_tx", tx_data, 'hA5);
    chk("rst_addr", reg_addr, 0);
    chk("rst_wdata", reg_wdata, 0);
    chk("rst_we", reg_we, 0);
    chk("rst_re", reg_re, 0);
    reset = 1'b1;
    tick(2);

    // Write burst
    b  = we_n;
    rb = re_n;
    cs = 1'b0;
    tick(2);
    chk("wr_busy", busy, 1);
    send_byte(8'h10);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    cs = 1'b1;
    tick(2);
    chk("wr_idle", busy, 0);
    chk("wr_cnt", we_n - b, 3);
    chk("wr_a0", wa(b), 'h10);
    chk("wr_d0", wd(b), 'h11);
    chk("wr_a1", wa(b + 1), 'h11);
    chk("wr_d1", wd(b + 1), 'h22);
    chk("wr_a2", wa(b + 2), 'h12);
    chk("wr_d2", wd(b + 2), 'h33);
    chk("wr_no_re", re_n - rb, 0);

    // Preload 0x20..0x22, then read them back
    cs = 1'b0;
    tick(2);
    send_byte(8'h20);
    send_byte(8'hDE);
    send_byte(8'hAD);
    send_byte(8'hBE);
    cs = 1'b1;
    tick(2);
    b  = we_n;
    rb = re_n;
    cs = 1'b0;
    tick(2);
    for (int i = 0; i < 4; i++) begin
      miso[i] = tx_data;
      send_byte((i == 0) ? 8'hA0 : 8'h00);
    end
    cs = 1'b1;
    tick(2);
    chk("rd_miso0", miso[0], 'hA5);
    chk("rd_miso1", miso[1], 'hDE);
    chk("rd_miso2", miso[2], 'hAD);
    chk("rd_miso3", miso[3], 'hBE);
    chk("rd_re_cnt", re_n - rb, 4);
    chk("rd_re0", ra(rb), 'h20);
    chk("rd_re1", ra(rb + 1), 'h21);
    chk("rd_re2", ra(rb + 2), 'h22);
    chk("rd_re3", ra(rb + 3), 'h23);
    chk("rd_no_we", we_n - b, 0);

    // Address wrap plus write latency
    b  = we_n;
    cs = 1'b0;
    tick(2);
    send_byte(8'h7F);
    rx_data  = 8'h01;
    rx_valid = 1'b1;
    chk("lat_we_before", reg_we, 0);
    tick(1);
    chk("lat_we", reg_we, 1);
    chk("lat_addr", reg_addr, 'h7F);
    chk("lat_wdata", reg_wdata, 'h01);
    tick(1);
    chk("lat_we_off", reg_we, 0);
    chk("wrap_addr", reg_addr, 'h00);
    tick(4);
    rx_valid = 1'b0;
    tick(6);
    send_byte(8'h02);
    cs = 1'b1;
    tick(2);
    chk("wrap_cnt", we_n - b, 2);
    chk("wrap_a0", wa(b), 'h7F);
    chk("wrap_a1", wa(b + 1), 'h00);
    chk("wrap_d1", wd(b + 1), 'h02);

    // Abort mid-byte, then read the untouched register
    cs = 1'b0;
    tick(2);
    send_byte(8'h05);
    send_byte(8'h5A);
    cs = 1'b1;
    tick(2);
    b  = we_n;
    cs = 1'b0;
    tick(2);
    send_byte(8'h05);
    tick(4);
    cs = 1'b1;
    tick(1);
    chk("abort_idle", busy, 0);
    chk("abort_we", reg_we, 0);
    tick(1);
    chk("abort_no_wr", we_n - b, 0);
    cs = 1'b0;
    tick(2);
    miso[0] = tx_data;
    send_byte(8'h85);
    miso[1] = tx_data;
    send_byte(8'h00);
    cs = 1'b1;
    tick(2);
    chk("abort_miso0", miso[0], 'hA5);
    chk("abort_miso1", miso[1], 'h5A);

    // Valid level held across a frame boundary
    b  = we_n;
    cs = 1'b0;
    tick(2);
    send_byte(8'h30);
    rx_data  = 8'h77;
    rx_valid = 1'b1;
    tick(3);
    cs      = 1'b1;
    rx_data = 8'h99;
    tick(3);
    chk("held_idle", busy, 0);
    rb = re_n;
    cs = 1'b0;
    tick(10);
    chk("held_busy", busy, 1);
    chk("held_addr", reg_addr, 'h31);
    chk("held_wr_cnt", we_n - b, 1);
    chk("held_no_re", re_n - rb, 0);
    rx_valid = 1'b0;
    tick(4);
    send_byte(8'h40);
    send_byte(8'h55);
    cs = 1'b1;
    tick(2);
    chk("held_cnt", we_n - b, 2);
    chk("held_d0", wd(b), 'h77);
    chk("held_a1", wa(b + 1), 'h40);
    chk("held_d1", wd(b + 1), 'h55);

    // Reset in the middle of a read burst
    cs = 1'b0;
    tick(2);
    send_byte(8'hA0);
    send_byte(8'h00);
    chk("mid_tx", tx_data, 'hAD);
    chk("mid_addr", reg_addr, 'h22);
    reset = 1'b0;
    #1;
    chk("mid_rst_tx", tx_data, 'hA5);
    chk("mid_rst_addr", reg_addr, 0);
    chk("mid_rst_wdata", reg_wdata, 0);
    chk("mid_rst_we", reg_we, 0);
    chk("mid_rst_re", reg_re, 0);
    chk("mid_rst_busy", busy, 0);
    tick(1);
    reset = 1'b1;
    tick(5);
    chk("post_rst_wait", busy, 0);
    cs = 1'b1;
    tick(2);
    cs = 1'b0;
    tick(2);
    chk("post_rst_frame", busy, 1);
    cs = 1'b1;
    tick(2);

    chk("no_overlap", overlap, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
